// File: rtl/fifo_frame_reader_pkg.sv
// Shared types, field layout and word builders for the FIFO frame reader.
// Header/footer words occupy the low 64 bits of the stream word.
package fifo_frame_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StHeader,
        StPayload,
        StFooter
    } state_e;

    typedef logic [15:0] frame_no_t;
    typedef logic [15:0] count_t;
    typedef logic [31:0] sum_t;

    localparam logic [7:0] HDR_MARK = 8'hAA;
    localparam logic [7:0] FTR_MARK = 8'h55;

    localparam int unsigned MARK_MSB  = 63;
    localparam int unsigned MARK_LSB  = 56;
    localparam int unsigned FIELD_MSB = 55;
    localparam int unsigned FIELD_LSB = 40;
    localparam int unsigned SUM_MSB   = 31;
    localparam int unsigned SUM_LSB   = 0;

    function automatic logic [63:0] make_header(input frame_no_t frame_no);
        logic [63:0] w;
        w = '0;
        w[MARK_MSB:MARK_LSB]   = HDR_MARK;
        w[FIELD_MSB:FIELD_LSB] = frame_no;
        return w;
    endfunction

    function automatic logic [63:0] make_footer(input count_t cnt, input sum_t sum);
        logic [63:0] w;
        w = '0;
        w[MARK_MSB:MARK_LSB]   = FTR_MARK;
        w[FIELD_MSB:FIELD_LSB] = cnt;
        w[SUM_MSB:SUM_LSB]     = sum;
        return w;
    endfunction

endpackage

// File: rtl/fifo_frame_reader_if.sv
// FIFO read port plus outgoing AXI4-Stream-style channel of the frame reader.
// master = the reader, slave = FIFO/downstream side.
interface fifo_frame_reader_if #(
    parameter int unsigned WIDTH = 64
);
    logic [WIDTH-1:0] FIFO_DOUT;
    logic             FIFO_NOT_EMPTY;
    logic             FIFO_RE;
    logic [WIDTH-1:0] M_TDATA;
    logic             M_TVALID;
    logic             M_TLAST;
    logic             M_TREADY;

    modport master (
        input  FIFO_DOUT,
        input  FIFO_NOT_EMPTY,
        input  M_TREADY,
        output FIFO_RE,
        output M_TDATA,
        output M_TVALID,
        output M_TLAST
    );

    modport slave (
        output FIFO_DOUT,
        output FIFO_NOT_EMPTY,
        output M_TREADY,
        input  FIFO_RE,
        input  M_TDATA,
        input  M_TVALID,
        input  M_TLAST
    );
endinterface

// File: rtl/fifo_frame_reader_out_stage.sv
// Single-entry valid/ready holding register driving the stream outputs.
// The caller only asserts load_i when the slot is empty or being drained.
module frame_out_stage #(
    parameter int unsigned WIDTH = 64
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             last_i,
    input  logic             tready_i,
    output logic [WIDTH-1:0] tdata_o,
    output logic             tvalid_o,
    output logic             tlast_o
);

    logic [WIDTH-1:0] data_q, data_d;
    logic             valid_q, valid_d;
    logic             last_q, last_d;

    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        last_d  = last_q;
        if (load_i) begin
            data_d  = data_i;
            valid_d = 1'b1;
            last_d  = last_i;
        end else if (tready_i) begin
            valid_d = 1'b0;
            last_d  = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            data_q  <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
            last_q  <= last_d;
        end
    end

    assign tdata_o  = data_q;
    assign tvalid_o = valid_q;
    assign tlast_o  = last_q;

endmodule

// File: rtl/fifo_frame_reader.sv
// Drains the threshold FIFO into framed stream packets: header, up to FRAME_LEN
// payload words, footer carrying word count and 32-bit checksum.
module fifo_frame_reader
    import fifo_frame_pkg::*;
#(
    parameter int unsigned WIDTH     = 64,
    parameter int unsigned FRAME_LEN = 16,
    parameter int unsigned TIMEOUT   = 256
) (
    input  logic                CLK,
    input  logic                RESET,
    input  logic                ENABLE,
    fifo_frame_reader_if.master bus,
    output logic                BUSY,
    output frame_no_t           FRAME_NO
);

    localparam count_t      FrameLen  = count_t'(FRAME_LEN);
    localparam logic [31:0] Timeout   = TIMEOUT;
    localparam bit          TimeoutEn = (TIMEOUT != 0);

    state_e      state_q, state_d;
    frame_no_t   frame_no_q, frame_no_d;
    count_t      cnt_q, cnt_d;
    sum_t        sum_q, sum_d;
    logic [31:0] idle_q, idle_d;

    logic             slot_free;
    logic             in_payload;
    logic             close;
    logic             pop;
    logic             handshake;
    logic             load;
    logic             load_last;
    logic [WIDTH-1:0] load_data;

    always_comb begin
        handshake  = bus.M_TVALID & bus.M_TREADY;
        slot_free  = ~bus.M_TVALID | bus.M_TREADY;
        in_payload = (state_q == StPayload);
        // Close wins over a pop so the footer never races a fresh payload word.
        close = in_payload & slot_free &
                ((cnt_q == FrameLen) |
                 (TimeoutEn & (idle_q == Timeout) & (cnt_q != '0)));
        pop   = in_payload & bus.FIFO_NOT_EMPTY & slot_free &
                (cnt_q < FrameLen) & ~close;
    end

    assign bus.FIFO_RE = pop;

    always_comb begin
        state_d    = state_q;
        frame_no_d = frame_no_q;
        cnt_d      = cnt_q;
        sum_d      = sum_q;
        idle_d     = idle_q;
        load       = 1'b0;
        load_last  = 1'b0;
        load_data  = '0;

        unique case (state_q)
            StIdle: begin
                if (ENABLE && bus.FIFO_NOT_EMPTY) begin
                    load            = 1'b1;
                    load_data[63:0] = make_header(frame_no_q);
                    state_d         = StHeader;
                end
            end
            StHeader: begin
                if (handshake) begin
                    state_d = StPayload;
                end
            end
            StPayload: begin
                if (close) begin
                    load            = 1'b1;
                    load_last       = 1'b1;
                    load_data[63:0] = make_footer(cnt_q, sum_q);
                    state_d         = StFooter;
                end else if (pop) begin
                    load      = 1'b1;
                    load_data = bus.FIFO_DOUT;
                    cnt_d     = cnt_q + count_t'(1);
                    sum_d     = sum_q + bus.FIFO_DOUT[31:0];
                    idle_d    = '0;
                end else if (idle_q != Timeout) begin
                    idle_d = idle_q + 32'd1;
                end
            end
            StFooter: begin
                if (handshake) begin
                    state_d    = StIdle;
                    frame_no_d = frame_no_q + 16'd1;
                    cnt_d      = '0;
                    sum_d      = '0;
                    idle_d     = '0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q    <= StIdle;
            frame_no_q <= '0;
            cnt_q      <= '0;
            sum_q      <= '0;
            idle_q     <= '0;
        end else begin
            state_q    <= state_d;
            frame_no_q <= frame_no_d;
            cnt_q      <= cnt_d;
            sum_q      <= sum_d;
            idle_q     <= idle_d;
        end
    end

    frame_out_stage #(
        .WIDTH(WIDTH)
    ) u_out_stage (
        .clk_i   (CLK),
        .rst_i   (RESET),
        .load_i  (load),
        .data_i  (load_data),
        .last_i  (load_last),
        .tready_i(bus.M_TREADY),
        .tdata_o (bus.M_TDATA),
        .tvalid_o(bus.M_TVALID),
        .tlast_o (bus.M_TLAST)
    );

    assign BUSY     = (state_q != StIdle);
    assign FRAME_NO = frame_no_q;

endmodule

// File: doc/fifo_frame_reader.md
# fifo_frame_reader

Read-side companion to the threshold FIFO. Drains captured samples from the FIFO and emits them as framed AXI4-Stream-style packets: one header word, up to FRAME_LEN payload words, one footer word carrying the count and a checksum. Sits between the FIFO read port and the readout/DMA stream, owning all FIFO_RE decisions.

## Interface
- WIDTH, 64: data word width; must be ≥ 64.
- FRAME_LEN, 16: maximum payload words per frame, 1..65535.
- TIMEOUT, 256: consecutive no-pop cycles in PAYLOAD before an early close; 0 disables timeout.

Ports:
- CLK  in  1  sole clock; all logic on rising edge.
- RESET  in  1  asynchronous, active-high reset.
- ENABLE  in  1  permits new frames to start.
- FIFO_DOUT  in  WIDTH  FIFO head word; valid whenever FIFO_NOT_EMPTY=1, advances the cycle after each pop.
- FIFO_NOT_EMPTY  in  1  FIFO holds ≥1 word.
- FIFO_RE  out  1  pop strobe, combinational from registered state.
- M_TDATA  out  WIDTH  stream data.
- M_TVALID  out  1  stream valid.
- M_TLAST  out  1  high on the footer word only.
- M_TREADY  in  1  downstream ready.
- BUSY  out  1  high in any state other than IDLE.
- FRAME_NO  out  16  number of the next/current frame.

## Operation
- States: IDLE, HEADER, PAYLOAD, FOOTER.
- IDLE → HEADER when ENABLE=1 and FIFO_NOT_EMPTY=1; header loaded into output register on the transition.
- Header: [63:56]=8'hAA, [55:40]=FRAME_NO, other bits 0.
- HEADER → PAYLOAD on header handshake (M_TVALID&M_TREADY).
- PAYLOAD: slot_free = !M_TVALID | M_TREADY. FIFO_RE = FIFO_NOT_EMPTY & slot_free & (cnt < FRAME_LEN). On pop, FIFO_DOUT loads into output register; cnt+1; sum += FIFO_DOUT[31:0] (32-bit, wraps).
- Idle counter: increments each PAYLOAD cycle without pop, clears on pop; saturates at TIMEOUT.
- PAYLOAD → FOOTER when slot_free and (cnt==FRAME_LEN, or TIMEOUT≠0 and idle counter==TIMEOUT and cnt≥1); footer loaded on transition. No pop in that cycle.
- Footer: [63:56]=8'h55, [55:40]=cnt, [39:32]=0, [31:0]=sum; M_TLAST=1.
- FOOTER → IDLE on footer handshake; FRAME_NO+1 (16-bit wrap); cnt, sum, idle counter cleared.
- ENABLE only gates IDLE→HEADER; deasserting mid-frame lets the frame complete normally.
- FIFO_RE never asserted when FIFO_NOT_EMPTY=0 or outside PAYLOAD.
- Backpressure: M_TDATA/M_TLAST stable while M_TVALID=1 and M_TREADY=0.

## Timing
- RESET asserted: immediately state=IDLE, M_TVALID=0, M_TDATA=0, M_TLAST=0, BUSY=0, FRAME_NO=0, cnt/sum/idle=0, FIFO_RE=0. Mid-frame reset aborts the frame; no footer.
- IDLE with NOT_EMPTY at edge n → header M_TVALID at n+1.
- Header accepted at edge n → first pop cycle n+1 → data valid n+2.
- PAYLOAD sustains one word/cycle with M_TREADY=1 and FIFO non-empty.
- Last payload accepted at edge n → footer valid n+1; minimum frame overhead 2 bubble-free words plus 1 turnaround cycle.
- Footer accepted at edge n, FIFO non-empty, ENABLE=1 → IDLE at n+1, next header valid n+2.

## Structure
- Package fifo_frame_pkg: state enum, HDR_MARK=8'hAA, FTR_MARK=8'h55, field bit positions, 16-bit FRAME_NO/count types.
- One sub-module: frame_out_stage — single-entry valid/ready holding register (load, data, last in; M_T* out); FSM, counters, checksum stay in the top.

## Test plan
- Reset: assert RESET mid-sim asynchronously → all outputs 0 before next CLK edge, FIFO_RE=0.
- FIFO preloaded with 1..16, M_TREADY=1, FRAME_LEN=16 → 0xAA00_0000_0000_0000, words 1..16 on consecutive cycles, footer 0x5500_1000_0000_0088 with TLAST.
- Same data, M_TREADY alternating 1/0 → identical 18-word sequence, exactly 16 pops, data stable during stalls.
- TIMEOUT=8, FIFO supplies 3 words (5,6,7) then stays empty → footer after 8 idle cycles, count=3, sum=0x12.
- Three back-to-back frames → header FRAME_NO 0,1,2; ENABLE dropped during frame 1 payload → frame 1 completes, frame 2 waits for ENABLE.
- RESET pulsed during frame 3 payload → output clears, no footer; next frame header carries FRAME_NO=0.
